// File: rtl/outport_arbiter_if.sv
// Handshake bundle between the five input FIFOs, the output port arbiter
// and the crossbar / output FIFO it controls.
// Vector bit order: bit0=L, bit1=N, bit2=E, bit3=W, bit4=S.
interface outport_arbiter_if;
  logic [4:0] req;        // input i has a head flit routed to this output
  logic [4:0] tail;       // head flit of input i is a tail flit
  logic       out_ready;  // output FIFO can accept a flit this cycle
  logic [4:0] grant;      // one-hot owner of the output, or zero
  logic [2:0] sel;        // binary index of the owner (crossbar select)
  logic [4:0] rd_en;      // pop strobes to the input FIFOs
  logic       out_valid;  // write strobe to the output FIFO
  logic       busy;       // output is locked to a packet

  // Request side: input FIFOs and downstream flow control
  modport master (
    output req, tail, out_ready,
    input  grant, sel, rd_en, out_valid, busy
  );

  // Arbiter side
  modport slave (
    input  req, tail, out_ready,
    output grant, sel, rd_en, out_valid, busy
  );
endinterface

// File: rtl/outport_arbiter.sv
// Wormhole output-port arbiter for a 5-port mesh router.
// Round-robin picks one requesting input in IDLE; the output then stays
// locked to that input until its tail flit has been transferred.
module outport_arbiter #(
  parameter int unsigned LAST_INIT = 4  // input treated as last-served at reset
) (
  input  logic               clk,
  input  logic               rst,
  outport_arbiter_if.slave   bus_if
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic [2:0] last_q,  last_d;

  logic [4:0] rd_en;
  logic [2:0] winner;
  logic       release_now;

  // Round-robin pick: search from (last+1) mod 5 upward with wrap, so the
  // most recently served input has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
    logic [2:0] pick;
    logic       found;
    logic [3:0] cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!found && r[cand[2:0]]) begin
        pick  = cand[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(bus_if.req, last_q);

  // Pop strobes: grant_q is zero outside LOCKED and during reset, so no
  // pop can ever be issued from IDLE.
  assign rd_en       = grant_q & bus_if.req & {5{bus_if.out_ready}};
  assign release_now = rd_en[sel_q] & bus_if.tail[sel_q];

  // Next-state and next-output decode
  always_comb begin
    // NOTE: every target gets a default before the case so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.req != 5'b0) begin
          grant_d = 5'b00001 << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Hold the lock across stalls and empty-FIFO gaps; only a tail
        // transfer releases it. sel keeps its value after release.
        if (release_now) begin
          grant_d = 5'b0;
          busy_d  = 1'b0;
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 5'b0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      last_q  <= 3'(LAST_INIT);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign bus_if.grant     = grant_q;
  assign bus_if.sel       = sel_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.rd_en     = rd_en;
  assign bus_if.out_valid = |rd_en;

endmodule
